p4_router_ingress_port_mux: RTL and testbench
=============================================

Name: p4_router_ingress_port_mux

Overview:
Ingress-side counterpart of the egress port adapter. Merges NUM_ING_PHYS_PORTS ingress AXIS streams, already width-converted and in the router core clock domain, onto the single P4 ingress bus. Arbitration is round-robin and frame-atomic. Each output beat is tagged with its source port on m_tid. Per-port enable gating and per-port frame/drop counters are included.

Parameters:
NUM_ING_PHYS_PORTS, 4, number of ingress ports (>=2, elab-checked)
DATA_BYTES, 8, bytes per beat on all ports (>0, elab-checked)
PORT_ID_WIDTH, $clog2(NUM_ING_PHYS_PORTS), width of m_tid (derived, min 1)
CNT_WIDTH, 32, width of each per-port counter (>=2)

Ports:
Widths use N=NUM_ING_PHYS_PORTS, D=DATA_BYTES.
clk  in  1  core clock
srst  in  1  synchronous active-high reset
s_tvalid  in  N  per-port valid
s_tready  out  N  per-port ready
s_tdata  in  N*D*8  port p at bits [p*D*8 +: D*8]
s_tkeep  in  N*D  per-port keep
s_tlast  in  N  per-port last
m_tvalid  out  1  merged valid
m_tready  in  1  merged ready
m_tdata  out  D*8  merged data
m_tkeep  out  D  merged keep
m_tlast  out  1  merged last
m_tid  out  PORT_ID_WIDTH  source port of the current beat
port_enable  in  N  per-port forward enable
cnt_clear  in  N  per-port counter clear strobe
frame_cnt  out  N*CNT_WIDTH  frames forwarded per port
drop_cnt  out  N*CNT_WIDTH  frames dropped (port disabled) per port

Behaviour:
- Reset (srst=1 at a clk edge) clears the following:
  - m_tvalid/m_tlast/m_tdata/m_tkeep/m_tid = 0.
  - All counters = 0.
  - FSM = IDLE.
  - RR pointer = N-1, so port 0 has first priority.
  - All per-port mode flags = START.
  - s_tready = 0 while srst is high.
- Per-port mode flags (START, FWD, SINK) determine frame fate at the first beat only:
  - START with port_enable=0 and s_tvalid=1: port goes to SINK. s_tready[p]=1 (combinational, independent of arbiter) until the tlast beat is accepted; on that beat drop_cnt[p]++ and the flag returns to START.
  - START with port_enable=1: port is an arbitration candidate.
  - A port changing port_enable mid-frame does not affect the current frame. A forwarded frame completes in full; a sunk frame is sunk in full.
- Arbiter FSM:
  - IDLE: candidates are ports with mode START, port_enable=1, s_tvalid=1.
  - If any candidate exists, grant the first one searching from RR pointer+1 with wrap. Register grant and set RR pointer = grant. Go to FWD. No s_tready is asserted in this cycle.
  - FWD: s_tready[grant] = !m_tvalid | m_tready; all other s_tready=0 (except SINK ports).
  - On an accepted beat with s_tlast: frame_cnt[grant]++ and go to IDLE.
  - There is exactly one bubble cycle between consecutive frames.
- Output stage:
  - Single register. Latency from input handshake to m_tvalid is 1 cycle.
  - m_* are loaded on the input handshake, with m_tid = grant.
  - m_tvalid clears when m_tready=1 and no new beat is loaded.
  - Full throughput within a frame when m_tready=1.
  - m_* hold stable while m_tvalid=1 and m_tready=0 (AXIS rule).
- Counters:
  - Saturate at all-ones (no wrap).
  - cnt_clear[p] has priority over a same-cycle increment; the result is 0.
  - Counter outputs are registered.
- Reset mid-frame: the output frame is truncated with no tlast. Downstream tolerates this via its own reset; no recovery logic is provided.
- Source tlast is trusted. No maximum-length timeout; a stalled source holds the grant indefinitely.

Test Plan:
1. Port 0 sends a 3-beat frame, others idle -> 3 output beats with m_tid=0, tlast on beat 3, data unchanged, first m_tvalid 2 cycles after s_tvalid; frame_cnt[0]=1.
2. Ports 0,1,2 each present a 2-beat frame in the same cycle -> output order port 0, 1, 2. No interleaving, 1 bubble between frames, m_tid=0,0,1,1,2,2. Next round starts at port 3, then port 0.
3. Random m_tready at 50% over 100 frames from 4 ports -> scoreboard matches per port with no lost or duplicated beats, and m_* stable during stalls.
4. port_enable[1]=0, port 1 sends 4 frames -> s_tready[1]=1 throughout, no output carries m_tid=1, drop_cnt[1]=4, frame_cnt[1]=0.
5. port_enable[0] deasserted on beat 2 of a 5-beat forwarded frame -> all 5 beats forwarded and frame_cnt[0]=1. The following frame is dropped: drop_cnt[0]=1.
6. CNT_WIDTH=4, port 2 sends 20 frames -> frame_cnt[2]=15. cnt_clear[2] pulsed in the same cycle as an accepted tlast -> frame_cnt[2]=0.

Source files
------------

// File: rtl/p4_router_ingress_port_mux.sv
// rtl/p4_router_ingress_port_mux.sv - round-robin frame-atomic merge of N ingress AXIS ports onto the P4 ingress bus
module p4_router_ingress_port_mux #(
  parameter int NUM_ING_PHYS_PORTS = 4,
  parameter int DATA_BYTES         = 8,
  parameter int PORT_ID_WIDTH      = (NUM_ING_PHYS_PORTS > 2) ? $clog2(NUM_ING_PHYS_PORTS) : 1,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                           clk,
  input  logic                                           srst,
  input  logic [NUM_ING_PHYS_PORTS-1:0]                  s_tvalid,
  output logic [NUM_ING_PHYS_PORTS-1:0]                  s_tready,
  input  logic [NUM_ING_PHYS_PORTS*DATA_BYTES*8-1:0]     s_tdata,
  input  logic [NUM_ING_PHYS_PORTS*DATA_BYTES-1:0]       s_tkeep,
  input  logic [NUM_ING_PHYS_PORTS-1:0]                  s_tlast,
  output logic                                           m_tvalid,
  input  logic                                           m_tready,
  output logic [DATA_BYTES*8-1:0]                        m_tdata,
  output logic [DATA_BYTES-1:0]                          m_tkeep,
  output logic                                           m_tlast,
  output logic [PORT_ID_WIDTH-1:0]                       m_tid,
  input  logic [NUM_ING_PHYS_PORTS-1:0]                  port_enable,
  input  logic [NUM_ING_PHYS_PORTS-1:0]                  cnt_clear,
  output logic [NUM_ING_PHYS_PORTS*CNT_WIDTH-1:0]        frame_cnt,
  output logic [NUM_ING_PHYS_PORTS*CNT_WIDTH-1:0]        drop_cnt
);

  localparam int N  = NUM_ING_PHYS_PORTS;
  localparam int DW = DATA_BYTES * 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  localparam logic [1:0] MODE_START = 2'd0;
  localparam logic [1:0] MODE_FWD   = 2'd1;
  localparam logic [1:0] MODE_SINK  = 2'd2;

  if (NUM_ING_PHYS_PORTS < 2) begin : g_chk_ports
    $error("NUM_ING_PHYS_PORTS must be >= 2");
  end
  if (DATA_BYTES < 1) begin : g_chk_bytes
    $error("DATA_BYTES must be > 0");
  end
  if (CNT_WIDTH < 2) begin : g_chk_cnt
    $error("CNT_WIDTH must be >= 2");
  end

  logic [0:0]                     state_q, state_d;
  logic [PORT_ID_WIDTH-1:0]       gnt_q, gnt_d;
  logic [PORT_ID_WIDTH-1:0]       rr_q, rr_d;
  logic [N-1:0][1:0]              mode_q, mode_d;
  logic                           m_tvalid_q, m_tvalid_d;
  logic                           m_tlast_q, m_tlast_d;
  logic [DW-1:0]                  m_tdata_q, m_tdata_d;
  logic [DATA_BYTES-1:0]          m_tkeep_q, m_tkeep_d;
  logic [PORT_ID_WIDTH-1:0]       m_tid_q, m_tid_d;
  logic [N-1:0][CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
  logic [N-1:0][CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

  logic [N-1:0]                   s_ready;
  logic [N-1:0]                   cand;
  logic [N-1:0]                   frame_inc;
  logic [N-1:0]                   drop_inc;
  logic                           found;
  logic [PORT_ID_WIDTH-1:0]       pick;
  logic                           out_free;
  logic                           fwd_hs;
  logic                           sel_valid;
  logic                           sel_last;
  logic [DW-1:0]                  sel_data;
  logic [DATA_BYTES-1:0]          sel_keep;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    mode_d      = mode_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tid_d     = m_tid_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    s_ready     = '0;
    cand        = '0;
    frame_inc   = '0;
    drop_inc    = '0;
    found       = 1'b0;
    pick        = '0;
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    sel_data    = '0;
    sel_keep    = '0;
    out_free    = !m_tvalid_q || m_tready;

    // Sinking ports accept unconditionally so a disabled source never backs up.
    for (int p = 0; p < N; p++) begin
      if (gnt_q == PORT_ID_WIDTH'(p)) begin
        sel_valid = s_tvalid[p];
        sel_last  = s_tlast[p];
        sel_data  = s_tdata[p*DW +: DW];
        sel_keep  = s_tkeep[p*DATA_BYTES +: DATA_BYTES];
      end
      if (mode_q[p] == MODE_SINK || (mode_q[p] == MODE_START && !port_enable[p])) begin
        s_ready[p] = 1'b1;
      end
      if (state_q == ST_FWD && gnt_q == PORT_ID_WIDTH'(p)) begin
        s_ready[p] = out_free;
      end
      cand[p] = (mode_q[p] == MODE_START) && port_enable[p] && s_tvalid[p];

      if (mode_q[p] == MODE_START) begin
        if (!port_enable[p] && s_tvalid[p]) begin
          if (s_tlast[p]) begin
            drop_inc[p] = 1'b1;
          end else begin
            mode_d[p] = MODE_SINK;
          end
        end
      end else if (mode_q[p] == MODE_SINK) begin
        if (s_tvalid[p] && s_tlast[p]) begin
          drop_inc[p] = 1'b1;
          mode_d[p]   = MODE_START;
        end
      end
    end

    fwd_hs = (state_q == ST_FWD) && out_free && sel_valid;

    if (fwd_hs) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = sel_last;
      m_tdata_d  = sel_data;
      m_tkeep_d  = sel_keep;
      m_tid_d    = gnt_q;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end

    if (state_q == ST_FWD) begin
      if (fwd_hs && sel_last) begin
        state_d = ST_IDLE;
        for (int p = 0; p < N; p++) begin
          if (gnt_q == PORT_ID_WIDTH'(p)) begin
            mode_d[p]    = MODE_START;
            frame_inc[p] = 1'b1;
          end
        end
      end
    end else begin
      // Two passes give round-robin order: ports above the pointer first, then wrap.
      for (int p = 0; p < N; p++) begin
        if (!found && cand[p] && PORT_ID_WIDTH'(p) > rr_q) begin
          found = 1'b1;
          pick  = PORT_ID_WIDTH'(p);
        end
      end
      for (int p = 0; p < N; p++) begin
        if (!found && cand[p]) begin
          found = 1'b1;
          pick  = PORT_ID_WIDTH'(p);
        end
      end
      if (found) begin
        gnt_d   = pick;
        rr_d    = pick;
        state_d = ST_FWD;
        for (int p = 0; p < N; p++) begin
          if (pick == PORT_ID_WIDTH'(p)) begin
            mode_d[p] = MODE_FWD;
          end
        end
      end
    end

    for (int p = 0; p < N; p++) begin
      if (cnt_clear[p]) begin
        frame_cnt_d[p] = '0;
        drop_cnt_d[p]  = '0;
      end else begin
        if (frame_inc[p] && frame_cnt_q[p] != {CNT_WIDTH{1'b1}}) begin
          frame_cnt_d[p] = frame_cnt_q[p] + CNT_WIDTH'(1);
        end
        if (drop_inc[p] && drop_cnt_q[p] != {CNT_WIDTH{1'b1}}) begin
          drop_cnt_d[p] = drop_cnt_q[p] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_q        <= PORT_ID_WIDTH'(N - 1);
      mode_q      <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tid_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      mode_q      <= mode_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tid_q     <= m_tid_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign s_tready  = srst ? '0 : s_ready;
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tdata   = m_tdata_q;
  assign m_tkeep   = m_tkeep_q;
  assign m_tid     = m_tid_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_p4_router_ingress_port_mux.sv
// tb/tb_p4_router_ingress_port_mux.sv - scoreboard bench for the ingress port mux
`timescale 1ns/1ps
module tb_p4_router_ingress_port_mux;
  localparam int NP = 4;
  localparam int DB = 8;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              srst;
  logic [NP-1:0]     s_tvalid, s_tready, s_tlast;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*DB-1:0]  s_tkeep;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [DB-1:0]     m_tkeep;
  logic [PW-1:0]     m_tid;
  logic [NP-1:0]     port_enable, cnt_clear;
  logic [NP*CW-1:0]  frame_cnt, drop_cnt;

  always #5 clk = ~clk;

  p4_router_ingress_port_mux #(
    .NUM_ING_PHYS_PORTS(NP), .DATA_BYTES(DB), .PORT_ID_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .srst(srst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .port_enable(port_enable), .cnt_clear(cnt_clear),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t in_q  [NP][$];
  beat_t exp_q [NP][$];
  int    log_tid[$];
  int    log_cyc[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  logic  rand_ready = 1'b0;
  logic  watch_sink = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int p, input int nb, input int fid, input bit fwd);
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      bt.data = {8'(p), 8'hA5, 16'(fid), 16'(b), 16'(nb)};
      bt.keep = (b == nb - 1) ? 8'h0F : 8'hFF;
      bt.last = (b == nb - 1);
      in_q[p].push_back(bt);
      if (fwd) exp_q[p].push_back(bt);
    end
  endtask

  task automatic drain(input string name);
    int  n;
    bit  busy;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
      busy = m_tvalid;
      for (int p = 0; p < NP; p++) begin
        if (in_q[p].size() != 0 || exp_q[p].size() != 0) busy = 1'b1;
      end
    end while (busy && n < 5000);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: outstanding traffic after %0d cycles", name, n);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic clear_cnts();
    @(posedge clk); #2;
    cnt_clear = '1;
    @(posedge clk); #2;
    cnt_clear = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    srst = 1'b0;
  endtask

  // Source drivers: handshake is decided at the negedge, the next beat is presented after posedge.
  initial begin
    logic [NP-1:0] hs;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p] && in_q[p].size() != 0) void'(in_q[p].pop_front());
        if (in_q[p].size() != 0) begin
          s_tvalid[p]            = 1'b1;
          s_tdata[p*DW +: DW]    = in_q[p][0].data;
          s_tkeep[p*DB +: DB]    = in_q[p][0].keep;
          s_tlast[p]             = in_q[p][0].last;
        end else begin
          s_tvalid[p] = 1'b0;
          s_tlast[p]  = 1'b0;
        end
      end
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: per-port scoreboard keyed by m_tid, plus stall-stability tracking.
  initial begin
    bit          stall_pend;
    logic [75:0] held;
    beat_t       e;
    stall_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (srst) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) check("stall_stable", 128'({m_tvalid, m_tid, m_tlast, m_tkeep, m_tdata}), 128'(held));
        if (m_tvalid && m_tready) begin
          log_tid.push_back(int'(m_tid));
          log_cyc.push_back(cyc);
          if (exp_q[m_tid].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: tid %0d data %0h with nothing expected", m_tid, m_tdata);
          end else begin
            e = exp_q[m_tid].pop_front();
            check("beat", 128'({m_tlast, m_tkeep, m_tdata}), 128'({e.last, e.keep, e.data}));
          end
        end
        if (watch_sink && s_tvalid[1]) check("sink_ready1", 128'(s_tready[1]), 128'(1));
        stall_pend = m_tvalid && !m_tready;
        held = {m_tvalid, m_tid, m_tlast, m_tkeep, m_tdata};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, acc;
    int exp_t2[6];
    exp_t2 = '{0, 0, 1, 1, 2, 2};
    srst = 1'b1;
    port_enable = '0;
    cnt_clear = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_s_tready", 128'(s_tready), 128'(0));
    check("rst_m_out", 128'({m_tvalid, m_tlast, m_tid, m_tkeep, m_tdata}), 128'(0));
    check("rst_cnts", 128'({frame_cnt, drop_cnt}), 128'(0));
    port_enable = '1;
    srst = 1'b0;

    // 1: single 3-beat frame, latency 2 from s_tvalid to m_tvalid
    push_frame(0, 3, 1, 1'b1);
    k = 0;
    while (!s_tvalid[0] && k < 20) begin @(negedge clk); k++; end
    n = 0;
    while (!m_tvalid && n < 20) begin @(negedge clk); n++; end
    check("t1_latency", 128'(n), 128'(2));
    drain("t1");
    check("t1_frame_cnt", 128'(frame_cnt), 128'(16'h0001));

    // 2: simultaneous 2-beat frames on ports 0..2, then round continues at port 3
    do_reset();
    log_tid.delete();
    log_cyc.delete();
    push_frame(0, 2, 10, 1'b1);
    push_frame(1, 2, 11, 1'b1);
    push_frame(2, 2, 12, 1'b1);
    drain("t2a");
    check("t2_beats", 128'(log_tid.size()), 128'(6));
    for (int i = 0; i < 6 && i < log_tid.size(); i++) check("t2_tid", 128'(log_tid[i]), 128'(exp_t2[i]));
    for (int i = 1; i < 6 && i < log_cyc.size(); i++)
      check("t2_gap", 128'(log_cyc[i] - log_cyc[i-1]), 128'((i % 2 == 0) ? 2 : 1));
    log_tid.delete();
    log_cyc.delete();
    push_frame(3, 1, 13, 1'b1);
    push_frame(0, 1, 14, 1'b1);
    drain("t2b");
    check("t2_round2_n", 128'(log_tid.size()), 128'(2));
    if (log_tid.size() == 2) begin
      check("t2_round2_first", 128'(log_tid[0]), 128'(3));
      check("t2_round2_second", 128'(log_tid[1]), 128'(0));
    end
    check("t2_frame_cnt", 128'(frame_cnt), 128'(16'h1112));

    // 3: 100 frames from all ports under random backpressure; counters saturate at 15
    clear_cnts();
    check("t3_clear", 128'({frame_cnt, drop_cnt}), 128'(0));
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) push_frame(f % NP, 1 + (f % 3), 100 + f, 1'b1);
    drain("t3");
    rand_ready = 1'b0;
    check("t3_frame_cnt", 128'(frame_cnt), 128'(16'hFFFF));
    check("t3_drop_cnt", 128'(drop_cnt), 128'(0));

    // 4: port 1 disabled, its frames are sunk while port 0 forwards
    clear_cnts();
    port_enable[1] = 1'b0;
    watch_sink = 1'b1;
    push_frame(1, 3, 200, 1'b0);
    push_frame(1, 1, 201, 1'b0);
    push_frame(1, 2, 202, 1'b0);
    push_frame(1, 4, 203, 1'b0);
    push_frame(0, 2, 204, 1'b1);
    drain("t4");
    watch_sink = 1'b0;
    port_enable[1] = 1'b1;
    check("t4_drop_cnt", 128'(drop_cnt), 128'(16'h0040));
    check("t4_frame_cnt", 128'(frame_cnt), 128'(16'h0001));

    // 5: enable dropped mid-frame; current frame completes, next is sunk
    clear_cnts();
    push_frame(0, 5, 300, 1'b1);
    acc = 0;
    k = 0;
    while (acc < 2 && k < 50) begin
      @(negedge clk);
      k++;
      if (s_tvalid[0] && s_tready[0]) acc++;
    end
    @(posedge clk); #2;
    port_enable[0] = 1'b0;
    push_frame(0, 3, 301, 1'b0);
    drain("t5");
    port_enable[0] = 1'b1;
    check("t5_frame_cnt", 128'(frame_cnt), 128'(16'h0001));
    check("t5_drop_cnt", 128'(drop_cnt), 128'(16'h0001));

    // 6: saturation at 15, then clear colliding with an accepted tlast
    clear_cnts();
    for (int f = 0; f < 20; f++) push_frame(2, 2, 400 + f, 1'b1);
    drain("t6a");
    check("t6_saturate", 128'(frame_cnt), 128'(16'h0F00));
    push_frame(2, 2, 420, 1'b1);
    k = 0;
    while (!(s_tvalid[2] && s_tready[2] && s_tlast[2]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_tlast_seen", 128'(s_tvalid[2] && s_tready[2] && s_tlast[2]), 128'(1));
    cnt_clear[2] = 1'b1;
    @(posedge clk); #2;
    cnt_clear[2] = 1'b0;
    drain("t6b");
    check("t6_clear_wins", 128'(frame_cnt), 128'(16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
